// File: rtl/spi_slave_transceiver_pkg.sv
// Shared definitions for the SPI slave transceiver: mode encodings, ss polarity
// constants, frame state type and a constant-width helper.
package spi_slave_transceiver_pkg;

    localparam int CPOL_IDLE_LOW        = 0;
    localparam int CPOL_IDLE_HIGH       = 1;
    localparam int CPHA_SAMPLE_LEADING  = 0;
    localparam int CPHA_SAMPLE_TRAILING = 1;
    localparam int SS_ACTIVE_LOW        = 0;
    localparam int SS_ACTIVE_HIGH       = 1;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } frame_state_t;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_slave_transceiver_input_sync.sv
// Synchronises ss/sclk/mosi into the system clock domain and derives ss
// assert/deassert strobes and sclk leading/trailing edge strobes.
module spi_input_sync
    import spi_slave_transceiver_pkg::*;
#(
    parameter int sync_stages   = 2,
    parameter int ss_polarity   = SS_ACTIVE_LOW,
    parameter int sclk_polarity = CPOL_IDLE_LOW
) (
    input  logic clock,
    input  logic reset,
    input  logic ss,
    input  logic sclk,
    input  logic mosi,
    output logic ss_active,
    output logic ss_assert,
    output logic ss_deassert,
    output logic lead_edge,
    output logic trail_edge,
    output logic mosi_sync
);

    localparam logic ss_active_level = (ss_polarity != SS_ACTIVE_LOW);
    localparam logic sclk_idle_level = (sclk_polarity != CPOL_IDLE_LOW);

    logic ss_sync;
    logic sclk_sync;

    generate
        if (sync_stages == 0) begin : g_bypass
            assign ss_sync   = ss;
            assign sclk_sync = sclk;
            assign mosi_sync = mosi;
        end else begin : g_sync
            logic [sync_stages-1:0] ss_chain;
            logic [sync_stages-1:0] sclk_chain;
            logic [sync_stages-1:0] mosi_chain;

            // Chains reset to the idle line levels so no edge is seen on release.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ss_chain   <= {sync_stages{~ss_active_level}};
                    sclk_chain <= {sync_stages{sclk_idle_level}};
                    mosi_chain <= '0;
                end else begin
                    ss_chain   <= (ss_chain << 1)   | sync_stages'(ss);
                    sclk_chain <= (sclk_chain << 1) | sync_stages'(sclk);
                    mosi_chain <= (mosi_chain << 1) | sync_stages'(mosi);
                end
            end

            assign ss_sync   = ss_chain[sync_stages-1];
            assign sclk_sync = sclk_chain[sync_stages-1];
            assign mosi_sync = mosi_chain[sync_stages-1];
        end
    endgenerate

    logic ss_now;
    logic ss_q;
    logic sclk_q;
    logic sclk_changed;

    assign ss_now = (ss_sync == ss_active_level);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ss_q   <= 1'b0;
            sclk_q <= sclk_idle_level;
        end else begin
            ss_q   <= ss_now;
            sclk_q <= sclk_sync;
        end
    end

    assign sclk_changed = (sclk_sync != sclk_q);
    assign ss_active    = ss_q;
    assign ss_assert    = ss_now && !ss_q;
    assign ss_deassert  = !ss_now && ss_q;
    assign lead_edge    = ss_q && sclk_changed && (sclk_sync != sclk_idle_level);
    assign trail_edge   = ss_q && sclk_changed && (sclk_sync == sclk_idle_level);

endmodule

// File: rtl/spi_slave_transceiver.sv
// Full-duplex SPI slave: oversampled serial side, inline TX FIFO feeding the
// miso shifter, and a word assembler presenting received mosi words.
module spi_slave_transceiver
    import spi_slave_transceiver_pkg::*;
#(
    parameter int                  bitcount      = 8,
    parameter int                  ss_polarity   = SS_ACTIVE_LOW,
    parameter int                  sclk_polarity = CPOL_IDLE_LOW,
    parameter int                  sclk_phase    = CPHA_SAMPLE_LEADING,
    parameter int                  msb_first     = 1,
    parameter int                  tx_depth      = 2,
    parameter logic [bitcount-1:0] idle_word     = '0,
    parameter int                  sync_stages   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ss,
    input  logic                sclk,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [bitcount-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [bitcount-1:0] rx_data,
    output logic                rx_valid,
    output logic                tx_underrun,
    output logic                frame_abort,
    output logic                busy
);

    localparam int                ptr_w    = clog2(tx_depth);
    localparam int                cnt_w    = clog2(bitcount);
    localparam logic [cnt_w-1:0]  last_bit = cnt_w'(bitcount - 1);
    localparam logic [cnt_w-1:0]  cnt_one  = cnt_w'(1);
    localparam logic [ptr_w:0]    ptr_one  = (ptr_w + 1)'(1);

    logic ss_active;
    logic ss_assert;
    logic ss_deassert;
    logic lead_edge;
    logic trail_edge;
    logic mosi_s;

    spi_input_sync #(
        .sync_stages  (sync_stages),
        .ss_polarity  (ss_polarity),
        .sclk_polarity(sclk_polarity)
    ) u_input_sync (
        .clock      (clock),
        .reset      (reset),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss_active  (ss_active),
        .ss_assert  (ss_assert),
        .ss_deassert(ss_deassert),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .mosi_sync  (mosi_s)
    );

    frame_state_t        state;
    logic [cnt_w-1:0]    bit_cnt;
    logic [bitcount-1:0] tx_shift;
    logic [bitcount-1:0] rx_shift;

    logic [bitcount-1:0] fifo_mem [tx_depth];
    logic [ptr_w:0]      wr_ptr;
    logic [ptr_w:0]      rd_ptr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ptr_w] != rd_ptr[ptr_w]) &&
                        (wr_ptr[ptr_w-1:0] == rd_ptr[ptr_w-1:0]);
    assign push       = tx_valid && !fifo_full;
    assign tx_ready   = !fifo_full;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[ptr_w-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + ptr_one;
        end
    end

    logic                in_frame;
    logic                sample_edge;
    logic                drive_edge;
    logic                load;
    logic                shift;
    logic [bitcount-1:0] load_word;
    logic [bitcount-1:0] rx_next;

    assign in_frame    = (state == ST_FRAME);
    assign sample_edge = in_frame && ((sclk_phase == CPHA_SAMPLE_LEADING) ? lead_edge : trail_edge);
    assign drive_edge  = in_frame && ((sclk_phase == CPHA_SAMPLE_LEADING) ? trail_edge : lead_edge);

    // With CPHA=0 the first bit must already be on miso before the first
    // sclk edge, so the word is loaded when ss is first seen active.
    assign load = (sclk_phase == CPHA_SAMPLE_LEADING)
                ? (ss_assert || (drive_edge && bit_cnt == '0))
                : (drive_edge && bit_cnt == '0);
    assign shift = drive_edge && (bit_cnt != '0);

    assign load_word = fifo_empty ? idle_word : fifo_mem[rd_ptr[ptr_w-1:0]];
    assign rx_next   = (msb_first != 0) ? {rx_shift[bitcount-2:0], mosi_s}
                                        : {mosi_s, rx_shift[bitcount-1:1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rd_ptr      <= '0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
            if (ss_deassert) begin
                state <= ST_IDLE;
                // A partial word is dropped; the TX word already popped is gone too.
                if (bit_cnt != '0) begin
                    frame_abort <= 1'b1;
                    bit_cnt     <= '0;
                    rx_shift    <= '0;
                end
            end else begin
                if (ss_assert) begin
                    state <= ST_FRAME;
                end
                if (load) begin
                    tx_shift    <= load_word;
                    miso        <= (msb_first != 0) ? load_word[bitcount-1] : load_word[0];
                    tx_underrun <= fifo_empty;
                    if (!fifo_empty) begin
                        rd_ptr <= rd_ptr + ptr_one;
                    end
                end else if (shift) begin
                    if (msb_first != 0) begin
                        miso     <= tx_shift[bitcount-2];
                        tx_shift <= {tx_shift[bitcount-2:0], 1'b0};
                    end else begin
                        miso     <= tx_shift[1];
                        tx_shift <= {1'b0, tx_shift[bitcount-1:1]};
                    end
                end
                if (sample_edge) begin
                    rx_shift <= rx_next;
                    if (bit_cnt == last_bit) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + cnt_one;
                    end
                end
            end
        end
    end

    assign busy    = ss_active;
    assign miso_oe = ss_active;

endmodule

// File: tb/tb_spi_slave_transceiver.sv
// Self-checking bench: two transceivers (mode 0 MSB-first, mode 3 LSB-first)
// driven by a bit-banged master and compared against a queue-based model.
module tb_spi_slave_transceiver;

    localparam int half = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] ss;
    logic [1:0] sclk;
    logic [1:0] mosi;
    logic [1:0] miso;
    logic [1:0] miso_oe;
    logic [1:0] tx_valid;
    logic [1:0] tx_ready;
    logic [1:0] rx_valid;
    logic [1:0] tx_underrun;
    logic [1:0] frame_abort;
    logic [1:0] busy;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    int total = 0;
    int bad   = 0;
    int rx_cnt [2] = '{0, 0};
    int ur_cnt [2] = '{0, 0};
    int ab_cnt [2] = '{0, 0};

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] model_rx [2];

    always #5 clock = ~clock;

    spi_slave_transceiver #(
        .bitcount(8), .ss_polarity(0), .sclk_polarity(0), .sclk_phase(0),
        .msb_first(1), .tx_depth(2), .idle_word(8'hFF), .sync_stages(2)
    ) dut_a (
        .clock(clock), .reset(reset), .ss(ss[0]), .sclk(sclk[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]), .busy(busy[0])
    );

    spi_slave_transceiver #(
        .bitcount(8), .ss_polarity(0), .sclk_polarity(1), .sclk_phase(1),
        .msb_first(0), .tx_depth(2), .idle_word(8'h00), .sync_stages(2)
    ) dut_b (
        .clock(clock), .reset(reset), .ss(ss[1]), .sclk(sclk[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1]), .busy(busy[1])
    );

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i] === 1'b1)    rx_cnt[i] = rx_cnt[i] + 1;
            if (tx_underrun[i] === 1'b1) ur_cnt[i] = ur_cnt[i] + 1;
            if (frame_abort[i] === 1'b1) ab_cnt[i] = ab_cnt[i] + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_size(input int w);
        return (w == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic model_load(input int w, output logic [7:0] word, output bit under);
        under = (model_size(w) == 0);
        if (w == 0) word = under ? 8'hFF : q_a.pop_front();
        else        word = under ? 8'h00 : q_b.pop_front();
    endtask

    task automatic push_word(input int w, input logic [7:0] d, input string tag);
        if (model_size(w) < 2) begin
            if (w == 0) q_a.push_back(d);
            else        q_b.push_back(d);
        end
        @(negedge clock);
        tx_data[w]  = d;
        tx_valid[w] = 1'b1;
        @(negedge clock);
        tx_valid[w] = 1'b0;
        check_output({tag, "_tx_ready"}, 32'(tx_ready[w]), 32'(model_size(w) < 2));
    endtask

    task automatic start_frame(input int w);
        ss[w] = 1'b0;
        repeat (half) @(negedge clock);
    endtask

    task automatic send_bits(input int w, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int k;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            k = (w == 0) ? 7 - i : i;
            if (w == 0) begin
                if (sclk[0]) sclk[0] = 1'b0;
                mosi[0] = mo[k];
                repeat (half) @(negedge clock);
                mi[k]   = miso[0];
                sclk[0] = 1'b1;
                repeat (half) @(negedge clock);
            end else begin
                sclk[1] = 1'b0;
                mosi[1] = mo[k];
                repeat (half) @(negedge clock);
                mi[k]   = miso[1];
                sclk[1] = 1'b1;
                repeat (half) @(negedge clock);
            end
        end
    endtask

    task automatic end_frame(input int w);
        if (w == 0 && sclk[0]) sclk[0] = 1'b0;
        repeat (half) @(negedge clock);
        ss[w] = 1'b1;
        repeat (half) @(negedge clock);
    endtask

    // One ss frame: k full words then an optional partial word of p bits.
    task automatic apply_stimulus(input int w, input int k, input int p,
                                  input logic [7:0] first_mo, input string tag);
        logic [7:0] exp_words [$];
        logic [7:0] word, mo, mi;
        bit under;
        int loads, exp_ur, first_ur, rx0, ur0, ab0;
        exp_ur   = 0;
        first_ur = 0;
        // Mode 0 also reloads on the trailing edge after each word's final sample.
        loads = (w == 0 || p > 0) ? k + 1 : k;
        for (int l = 0; l < loads; l++) begin
            model_load(w, word, under);
            exp_words.push_back(word);
            exp_ur = exp_ur + int'(under);
            if (l == 0) first_ur = int'(under);
        end
        rx0 = rx_cnt[w];
        ur0 = ur_cnt[w];
        ab0 = ab_cnt[w];
        start_frame(w);
        check_output({tag, "_busy"}, 32'(busy[w]), 32'(1));
        check_output({tag, "_miso_oe"}, 32'(miso_oe[w]), 32'(1));
        if (w == 0) check_output({tag, "_underrun_at_ss"}, 32'(ur_cnt[0] - ur0), 32'(first_ur));
        for (int j = 0; j < k; j++) begin
            mo = (j == 0) ? first_mo : 8'($urandom);
            send_bits(w, mo, 8, mi);
            check_output($sformatf("%s_miso_word%0d", tag, j), 32'(mi), 32'(exp_words[j]));
            model_rx[w] = mo;
        end
        if (p > 0) send_bits(w, 8'($urandom), p, mi);
        end_frame(w);
        check_output({tag, "_busy_end"}, 32'(busy[w]), 32'(0));
        check_output({tag, "_rx_data"}, 32'(rx_data[w]), 32'(model_rx[w]));
        check_output({tag, "_rx_valid_count"}, 32'(rx_cnt[w] - rx0), 32'(k));
        check_output({tag, "_abort_count"}, 32'(ab_cnt[w] - ab0), 32'(p > 0));
        check_output({tag, "_underrun_count"}, 32'(ur_cnt[w] - ur0), 32'(exp_ur));
    endtask

    initial begin
        logic [7:0] mi;
        int npush, k, p;
        reset       = 1'b0;
        ss          = 2'b11;
        sclk        = 2'b10;
        mosi        = 2'b00;
        tx_valid    = 2'b00;
        tx_data[0]  = '0;
        tx_data[1]  = '0;
        model_rx[0] = '0;
        model_rx[1] = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("reset_miso%0d", i), 32'(miso[i]), 32'(0));
            check_output($sformatf("reset_miso_oe%0d", i), 32'(miso_oe[i]), 32'(0));
            check_output($sformatf("reset_rx_data%0d", i), 32'(rx_data[i]), 32'(0));
            check_output($sformatf("reset_rx_valid%0d", i), 32'(rx_valid[i]), 32'(0));
            check_output($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'(0));
            check_output($sformatf("reset_tx_ready%0d", i), 32'(tx_ready[i]), 32'(1));
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("[TB] mode 0 single word, FIFO preloaded 0x3B");
        push_word(0, 8'h3B, "m0_push");
        apply_stimulus(0, 1, 0, 8'hA5, "m0_word");

        $display("[TB] empty FIFO sends idle word");
        apply_stimulus(0, 1, 0, 8'($urandom), "idle");

        $display("[TB] FIFO overflow with no SPI activity");
        push_word(0, 8'h61, "ovf_push1");
        push_word(0, 8'h72, "ovf_push2");
        push_word(0, 8'h83, "ovf_push3");
        apply_stimulus(0, 2, 0, 8'($urandom), "ovf_drain");

        $display("[TB] ss released mid-word");
        push_word(0, 8'hC4, "abort_push1");
        push_word(0, 8'h5D, "abort_push2");
        apply_stimulus(0, 0, 5, 8'h00, "abort");
        apply_stimulus(0, 1, 0, 8'($urandom), "after_abort");

        $display("[TB] mode 3 LSB-first two-word frame");
        push_word(1, 8'h8E, "m3_push1");
        push_word(1, 8'h12, "m3_push2");
        apply_stimulus(1, 2, 0, 8'($urandom), "m3_frame");
        check_output("m3_tx_ready_after", 32'(tx_ready[1]), 32'(1));

        $display("[TB] randomized frames");
        for (int it = 0; it < 8; it++) begin
            int w;
            w     = it % 2;
            npush = $urandom_range(0, 3);
            for (int n = 0; n < npush; n++) push_word(w, 8'($urandom), $sformatf("rnd%0d_push", it));
            k = $urandom_range(1, 2);
            p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            apply_stimulus(w, k, p, 8'($urandom), $sformatf("rnd%0d", it));
        end

        $display("[TB] reset mid-word");
        push_word(0, 8'h9A, "rst_push");
        start_frame(0);
        send_bits(0, 8'($urandom), 4, mi);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_output("rst_mid_miso", 32'(miso[0]), 32'(0));
        check_output("rst_mid_miso_oe", 32'(miso_oe[0]), 32'(0));
        check_output("rst_mid_rx_data", 32'(rx_data[0]), 32'(0));
        check_output("rst_mid_busy", 32'(busy[0]), 32'(0));
        check_output("rst_mid_underrun", 32'(tx_underrun[0]), 32'(0));
        check_output("rst_mid_abort", 32'(frame_abort[0]), 32'(0));
        check_output("rst_mid_tx_ready", 32'(tx_ready[0]), 32'(1));
        ss[0]   = 1'b1;
        sclk[0] = 1'b0;
        mosi[0] = 1'b0;
        q_a.delete();
        q_b.delete();
        model_rx[0] = '0;
        model_rx[1] = '0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        push_word(0, 8'h4E, "post_rst_push");
        apply_stimulus(0, 1, 0, 8'($urandom), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
